// File: rtl/msm_pkg.sv
// -----------------------------------------------------------------------------
// msm_pkg -- shared definitions for the master_sm game-state controller.
//
// Contents:
//   STATE_W  : width of the encoded game state (2 bits)
//   state_t  : game state encoding ST_IDLE=0, ST_PLAY=1, ST_WIN=2 (3 unused)
//   NUM_BTNS : number of push-buttons handled by the controller
// -----------------------------------------------------------------------------
package msm_pkg;

  localparam int STATE_W  = 2;
  localparam int NUM_BTNS = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

endpackage : msm_pkg

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync -- two-flop synchronizer plus rising-edge detector for one raw
// asynchronous push-button level.
//
// Ports:
//   clk_i   in   system clock, rising edge
//   rst_i   in   synchronous active-high reset, clears all three flops
//   btn_i   in   raw asynchronous button level, active-high
//   press_o out  one-cycle pulse per 0->1 transition of the synchronized level
//
// A button held through reset produces one press after reset releases,
// because the edge flop is cleared to 0 along with the synchronizer.
// -----------------------------------------------------------------------------
module btn_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  // Power-up value 0 so the chain is quiet even without a reset pulse.
  logic sync1_q = 1'b0;
  logic sync2_q = 1'b0;
  logic edge_q  = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Synchronized level is high now but was low one cycle ago.
  assign press_o = sync2_q & ~edge_q;

endmodule : btn_sync

// File: rtl/master_sm.sv
// -----------------------------------------------------------------------------
// master_sm -- top-level game-state controller: IDLE -> PLAY -> WIN.
//
// Parameters:
//   TARGET_SCORE     score at which PLAY moves to WIN
//   WIN_HOLD_CYCLES  WIN dwell time in cycles (timeout build only)
//
// Ports:
//   CLK          in   system clock, rising edge
//   RESET        in   synchronous active-high reset, highest priority
//   LEFT/RIGHT/UP/DOWN in raw asynchronous push-button levels, active-high
//   SCORE_COUNT  in   current score (4-bit unsigned), synchronous to CLK
//   STATE        out  registered game state (0 IDLE, 1 PLAY, 2 WIN)
//
// Build option:
//   MSM_WIN_TIMEOUT_EN  when defined, WIN returns to IDLE after
//                       WIN_HOLD_CYCLES cycles; otherwise WIN is held until
//                       RESET and no timer exists.
// -----------------------------------------------------------------------------
module master_sm
  import msm_pkg::*;
#(
  parameter int unsigned TARGET_SCORE    = 10,
  parameter int unsigned WIN_HOLD_CYCLES = 100000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       UP,
  input  logic       DOWN,
  input  logic [3:0] SCORE_COUNT,
  output logic [1:0] STATE
);

  // ---------------------------------------------------------------------------
  // Button conditioning: one synchronizer/edge detector per button.
  // ---------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;
  logic                any_press;

  assign btn_raw = {DOWN, UP, RIGHT, LEFT};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_sync u_btn_sync (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_i   (btn_raw[gi]),
        .press_o (btn_press[gi])
      );
    end
  endgenerate

  assign any_press = |btn_press;

  // ---------------------------------------------------------------------------
  // Score comparison, widened so any TARGET_SCORE value compares correctly.
  // ---------------------------------------------------------------------------
  logic score_hit;
  assign score_hit = (32'(SCORE_COUNT) >= TARGET_SCORE);

  // ---------------------------------------------------------------------------
  // State register and next-state logic.
  // ---------------------------------------------------------------------------
  state_t state_q = ST_IDLE;
  state_t state_d;

`ifdef MSM_WIN_TIMEOUT_EN
  // Guard against a 0-bit vector when WIN_HOLD_CYCLES is 1.
  localparam int TIMER_W = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] WIN_LAST = TIMER_W'(WIN_HOLD_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q = '0;
  logic [TIMER_W-1:0] timer_d;
  logic               win_done;

  assign win_done = (timer_q == WIN_LAST);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_press) state_d = ST_PLAY;
      ST_PLAY: if (score_hit) state_d = ST_WIN;
`ifdef MSM_WIN_TIMEOUT_EN
      ST_WIN:  if (win_done)  state_d = ST_IDLE;
`else
      ST_WIN:  state_d = ST_WIN;
`endif
      default: state_d = ST_IDLE;  // unused encoding recovers to IDLE
    endcase
  end

`ifdef MSM_WIN_TIMEOUT_EN
  // Counts cycles spent in WIN; zero whenever WIN is not being continued so
  // every WIN visit starts counting from 0.
  always_comb begin
    timer_d = '0;
    if (state_q == ST_WIN && state_d == ST_WIN) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE = state_q;

endmodule : master_sm

// File: tb/tb_master_sm.sv
// -----------------------------------------------------------------------------
// tb_master_sm -- directed self-checking bench for master_sm.
// Inputs change and STATE is sampled 1 ns after each rising edge.
// The WIN timeout section runs when MSM_WIN_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_master_sm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LEFT = 1'b0;
  logic       RIGHT = 1'b0;
  logic       UP = 1'b0;
  logic       DOWN = 1'b0;
  logic [3:0] SCORE_COUNT = 4'd0;
  logic [1:0] STATE;

  int total_checks = 0;
  int failed_checks = 0;

  master_sm #(
    .TARGET_SCORE    (10),
    .WIN_HOLD_CYCLES (8)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LEFT        (LEFT),
    .RIGHT       (RIGHT),
    .UP          (UP),
    .DOWN        (DOWN),
    .SCORE_COUNT (SCORE_COUNT),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] exp);
    total_checks++;
    assert (STATE === exp)
    else begin
      failed_checks++;
      $error("FAIL %s: STATE=%0d expected %0d", tag, STATE, exp);
    end
    $display("check %-14s STATE=%0d expected=%0d", tag, STATE, exp);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #1;
    // Power-up without reset: all inputs low for 100 cycles, IDLE throughout.
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 10 == 9) chk("noreset_idle", 2'd0);
    end

    // LEFT held 50 cycles: PLAY on exactly the 3rd edge, kept after release.
    LEFT = 1'b1;
    tick(); chk("left_edge1", 2'd0);
    tick(); chk("left_edge2", 2'd0);
    tick(); chk("left_edge3", 2'd1);
    for (int i = 3; i < 50; i++) tick();
    chk("left_held", 2'd1);
    LEFT = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("left_fall", 2'd1);

    // Buttons ignored in PLAY.
    UP = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    UP = 1'b0;
    tick(); chk("play_ign_btn", 2'd1);

    // Score below target keeps PLAY; reaching target gives WIN one edge later.
    SCORE_COUNT = 4'd9;
    for (int i = 0; i < 4; i++) tick();
    chk("score9", 2'd1);
    SCORE_COUNT = 4'd10;
    chk("score10_pre", 2'd1);
    tick(); chk("score10_win", 2'd2);
    SCORE_COUNT = 4'd0;
    DOWN = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    DOWN = 1'b0;
`ifndef MSM_WIN_TIMEOUT_EN
    chk("win_hold", 2'd2);
`endif

    // Reset out of WIN takes effect on the same edge.
    if (STATE == 2'd2 || STATE == 2'd0) begin end
    RESET = 1'b1;
    tick(); chk("reset_in_win", 2'd0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_after_rst", 2'd0);

    // UP and DOWN pulsed together for one cycle: one transition to PLAY.
    UP = 1'b1; DOWN = 1'b1;
    tick(); chk("updn_edge1", 2'd0);
    UP = 1'b0; DOWN = 1'b0;
    tick(); chk("updn_edge2", 2'd0);
    tick(); chk("updn_edge3", 2'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("updn_stay", 2'd1);

    // Reset in PLAY, then IDLE must stay with no stray press.
    RESET = 1'b1;
    tick(); chk("reset_in_play", 2'd0);
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("no_2nd_press", 2'd0);

    // Button held through reset: one press after release plus sync latency.
    RIGHT = 1'b1;
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("held_in_rst", 2'd0);
    RESET = 1'b0;
    tick(); chk("held_rel1", 2'd0);
    tick(); chk("held_rel2", 2'd0);
    tick(); chk("held_rel3", 2'd1);
    RIGHT = 1'b0;
    do_reset();
    chk("reset_again", 2'd0);

`ifdef MSM_WIN_TIMEOUT_EN
    // WIN lasts exactly 8 cycles, then IDLE; held RIGHT must not restart.
    LEFT = 1'b1;
    tick(); tick(); tick();
    chk("to_play", 2'd1);
    LEFT = 1'b0;
    RIGHT = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    SCORE_COUNT = 4'd12;
    tick(); chk("to_win", 2'd2);
    SCORE_COUNT = 4'd0;
    for (int i = 1; i < 8; i++) begin
      tick(); chk("win_dwell", 2'd2);
    end
    tick(); chk("win_timeout", 2'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("no_restart", 2'd0);
    RIGHT = 1'b0;
`endif

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule : tb_master_sm
